// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing the shared-memory datapath,
// with ALU/branch decode, memory wait states, illegal-instruction trap and retire pulse.
module multicycle_controller #(
  parameter int unsigned ALU_CTRL_W      = 4,
  parameter bit          MEM_WAIT_EN     = 1'b1,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic                  Zero,
  input  logic                  LessS,
  input  logic                  LessU,
  input  logic                  MemReady,
  output logic                  MemReq,
  output logic                  IRWrite,
  output logic                  MemWrite,
  output logic                  AdrSrc,
  output logic                  PCWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [2:0]            ImmSrc,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  Retire,
  output logic                  Illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLT = 4'd5, ALU_SLTU = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JALR, S_JAL, S_UPPER, S_ILLEGAL
  } state_t;

  state_t     state, state_next;
  logic       illegal_q;
  logic [3:0] alu_code;
  logic       mem_ready;
  logic       taken;

  assign mem_ready  = MEM_WAIT_EN ? MemReady : 1'b1;
  assign ALUControl = ALU_CTRL_W'(alu_code);
  assign Illegal    = illegal_q;

  // func3 to ALU operation; alt selects SUB/SRA where the instruction allows it
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    case (func3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = LessS;
      3'b101:  taken = ~LessS;
      3'b110:  taken = LessU;
      3'b111:  taken = ~LessU;
      default: taken = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  // Sticky illegal flag, set on the transition into ILLEGAL
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       illegal_q <= 1'b0;
    else if (state_next == S_ILLEGAL) illegal_q <= 1'b1;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:      state_next = (func7 == 7'b0000000 || func7 == 7'b0100000) ? S_EXECR : S_ILLEGAL;
          OP_I:      state_next = S_EXECI;
          OP_BRANCH: state_next = (func3 == 3'b010 || func3 == 3'b011) ? S_ILLEGAL : S_BRANCH;
          OP_JAL:    state_next = S_JAL;
          OP_JALR:   state_next = S_JALR;
          OP_LUI, OP_AUIPC: state_next = S_UPPER;
          default:   state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL, S_UPPER: state_next = S_ALUWB;
      S_ALUWB, S_BRANCH: state_next = S_FETCH;
      S_JALR:     state_next = S_JAL;
      S_ILLEGAL:  state_next = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    MemReq    = 1'b0;
    IRWrite   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    Retire    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ImmSrc    = 3'b000;
    alu_code  = ALU_ADD;
    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        Retire    = 1'b1;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        Retire   = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA  = 2'b10;
        alu_code = alu_dec(func3, func7[5]);
      end
      S_EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        alu_code = alu_dec(func3, func7[5] && func3 == 3'b101);
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        Retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 2'b10;
        alu_code = ALU_SUB;
        PCWrite  = taken;
        Retire   = 1'b1;
      end
      S_JALR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_UPPER: begin
        ALUSrcA = (opcode == OP_LUI) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b100;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: a per-instruction expected-cycle list built from the
// instruction semantics is compared cycle by cycle against two controller configurations.
module tb_multicycle_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic       zero, less_s, less_u, mem_ready, b_mem_ready;

  logic mem_req, ir_write, mem_write, adr_src, pc_write, reg_write, retire, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic b_mem_req, b_ir_write, b_mem_write, b_adr_src, b_pc_write, b_reg_write, b_retire, b_illegal;
  logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b;
  logic [2:0] b_imm_src;
  logic [3:0] b_alu_control;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .Zero(zero), .LessS(less_s), .LessU(less_u), .MemReady(mem_ready),
    .MemReq(mem_req), .IRWrite(ir_write), .MemWrite(mem_write), .AdrSrc(adr_src),
    .PCWrite(pc_write), .RegWrite(reg_write), .ResultSrc(result_src), .ALUSrcA(alu_src_a),
    .ALUSrcB(alu_src_b), .ImmSrc(imm_src), .ALUControl(alu_control), .Retire(retire),
    .Illegal(illegal));

  multicycle_controller #(.ALU_CTRL_W(4), .MEM_WAIT_EN(1'b0), .HALT_ON_ILLEGAL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .func3(func3), .func7(func7),
    .Zero(zero), .LessS(less_s), .LessU(less_u), .MemReady(b_mem_ready),
    .MemReq(b_mem_req), .IRWrite(b_ir_write), .MemWrite(b_mem_write), .AdrSrc(b_adr_src),
    .PCWrite(b_pc_write), .RegWrite(b_reg_write), .ResultSrc(b_result_src), .ALUSrcA(b_alu_src_a),
    .ALUSrcB(b_alu_src_b), .ImmSrc(b_imm_src), .ALUControl(b_alu_control), .Retire(b_retire),
    .Illegal(b_illegal));

  typedef struct packed {
    logic memreq, irwrite, pcwrite, regwrite, memwrite, adrsrc, retire, ill;
    logic [1:0] res, srca, srcb;
    logic [2:0] imm;
    logic [3:0] alu;
  } step_t;

  step_t act_a, act_b;
  assign act_a = {mem_req, ir_write, pc_write, reg_write, mem_write, adr_src, retire, illegal,
                  result_src, alu_src_a, alu_src_b, imm_src, alu_control};
  assign act_b = {b_mem_req, b_ir_write, b_pc_write, b_reg_write, b_mem_write, b_adr_src, b_retire,
                  b_illegal, b_result_src, b_alu_src_a, b_alu_src_b, b_imm_src, b_alu_control};

  step_t q[$];
  logic  rq[$];
  int    n_checks = 0;
  int    n_err = 0;
  logic [3:0] alu_tab [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic alt);
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd9;
    return alu_tab[f3];
  endfunction

  function automatic step_t fetch_step(input logic rdy, input logic ill);
    step_t s = '0;
    s.memreq = 1'b1; s.srcb = 2'd2; s.res = 2'd2;
    s.irwrite = rdy; s.pcwrite = rdy; s.ill = ill;
    return s;
  endfunction

  task automatic push(input step_t s, input logic r);
    q.push_back(s);
    rq.push_back(r);
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle list for one instruction
  task automatic build(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic ls, input logic lu, input int wf, input int wm);
    step_t s, wb;
    logic  bad;
    q.delete(); rq.delete();
    bad = 1'b0;
    wb = '0; wb.regwrite = 1'b1; wb.retire = 1'b1;
    repeat (wf) push(fetch_step(1'b0, 1'b0), 1'b0);
    push(fetch_step(1'b1, 1'b0), 1'b1);
    s = '0; s.srca = 2'd1; s.srcb = 2'd1; s.imm = (opc == 7'b1101111) ? 3'd3 : 3'd2;
    push(s, rnd());
    case (opc)
      7'b0000011, 7'b0100011: begin
        s = '0; s.srca = 2'd2; s.srcb = 2'd1; s.imm = (opc == 7'b0100011) ? 3'd1 : 3'd0;
        push(s, rnd());
        s = '0; s.memreq = 1'b1; s.adrsrc = 1'b1; s.memwrite = (opc == 7'b0100011);
        repeat (wm) push(s, 1'b0);
        if (opc == 7'b0100011) begin
          s.retire = 1'b1; push(s, 1'b1);
        end else begin
          push(s, 1'b1);
          s = '0; s.res = 2'd1; s.regwrite = 1'b1; s.retire = 1'b1; push(s, rnd());
        end
      end
      7'b0110011: begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          s = '0; s.srca = 2'd2; s.alu = alu_ref(f3, f7[5]); push(s, rnd());
          push(wb, rnd());
        end else bad = 1'b1;
      end
      7'b0010011: begin
        s = '0; s.srca = 2'd2; s.srcb = 2'd1; s.alu = alu_ref(f3, f7[5] && f3 == 3'd5);
        push(s, rnd()); push(wb, rnd());
      end
      7'b1100011: begin
        if (f3 == 3'd2 || f3 == 3'd3) bad = 1'b1;
        else begin
          s = '0; s.srca = 2'd2; s.alu = 4'd1; s.retire = 1'b1;
          case (f3)
            3'd0: s.pcwrite = z;   3'd1: s.pcwrite = !z;
            3'd4: s.pcwrite = ls;  3'd5: s.pcwrite = !ls;
            3'd6: s.pcwrite = lu;  default: s.pcwrite = !lu;
          endcase
          push(s, rnd());
        end
      end
      7'b1101111, 7'b1100111: begin
        if (opc == 7'b1100111) begin
          s = '0; s.srca = 2'd2; s.srcb = 2'd1; push(s, rnd());
        end
        s = '0; s.srca = 2'd1; s.srcb = 2'd2; s.pcwrite = 1'b1; push(s, rnd());
        push(wb, rnd());
      end
      7'b0110111, 7'b0010111: begin
        s = '0; s.srcb = 2'd1; s.imm = 3'd4; s.srca = (opc == 7'b0110111) ? 2'd3 : 2'd1;
        push(s, rnd()); push(wb, rnd());
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      s = '0; s.ill = 1'b1;
      repeat (3) push(s, rnd());
    end
  endtask

  // Steps through the first n expected cycles; dut_b runs with a random MemReady
  task automatic run(input string name, input bit chk_b, input int n);
    for (int i = 0; i < n; i++) begin
      mem_ready = rq[i];
      b_mem_ready = rnd();
      @(negedge clk);
      check($sformatf("%s[%0d]", name, i), 32'(act_a), 32'(q[i]));
      if (chk_b) check($sformatf("%s_b[%0d]", name, i), 32'(act_b), 32'(q[i]));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_instr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic z, input logic ls, input logic lu,
                          input int wf, input int wm, input bit chk_b);
    opcode = opc; func3 = f3; func7 = f7; zero = z; less_s = ls; less_u = lu;
    build(opc, f3, f7, z, ls, lu, wf, wm);
    run(name, chk_b, q.size());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b1; b_mem_ready = 1'b1;
    #2;
    check("reset_a", 32'(act_a), 32'(fetch_step(1'b1, 1'b0)));
    check("reset_b", 32'(act_b), 32'(fetch_step(1'b1, 1'b0)));
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic rand_instr(input string name, input int wmax, input bit chk_b);
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [2:0] bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    opc = ops[$urandom_range(0, 8)];
    f3  = (opc == 7'b1100011) ? bf3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
    f7  = rnd() ? 7'h20 : 7'h00;
    do_instr(name, opc, f3, f7, rnd(), rnd(), rnd(),
             $urandom_range(0, wmax), $urandom_range(0, wmax), chk_b);
  endtask

  initial begin
    opcode = '0; func3 = '0; func7 = '0; zero = 0; less_s = 0; less_u = 0;
    #1;
    do_reset();

    do_instr("add",   7'b0110011, 3'd0, 7'h00, 0, 0, 0, 0, 0, 1'b1);
    do_instr("sub",   7'b0110011, 3'd0, 7'h20, 0, 0, 0, 0, 0, 1'b1);
    do_instr("bne_t", 7'b1100011, 3'd1, 7'h00, 0, 0, 0, 0, 0, 1'b1);
    do_instr("bne_n", 7'b1100011, 3'd1, 7'h00, 1, 0, 0, 0, 0, 1'b1);
    do_instr("bltu",  7'b1100011, 3'd6, 7'h00, 0, 0, 1, 0, 0, 1'b1);
    do_instr("jalr",  7'b1100111, 3'd0, 7'h00, 0, 0, 0, 0, 0, 1'b1);
    do_instr("srai",  7'b0010011, 3'd5, 7'h20, 0, 0, 0, 0, 0, 1'b1);
    do_instr("addi",  7'b0010011, 3'd0, 7'h20, 0, 0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 60; k++) rand_instr("rnd0", 0, 1'b1);

    do_instr("lw_wait", 7'b0000011, 3'd2, 7'h00, 0, 0, 0, 2, 3, 1'b0);
    check("lw_len", 32'(q.size()), 32'd10);
    for (int k = 0; k < 60; k++) rand_instr("rndw", 3, 1'b0);

    // Illegal opcode: dut halts, dut_b returns to FETCH with the flag kept
    do_reset();
    opcode = 7'h7F; func3 = '0; func7 = '0;
    build(7'h7F, 3'd0, 7'h00, 0, 0, 0, 0, 0);
    run("ill", 1'b1, 3);
    mem_ready = 1'b1; b_mem_ready = 1'b1;
    @(negedge clk);
    check("ill_hold1", 32'(act_a), 32'(q[3]));
    check("ill_b_fetch", 32'(act_b), 32'(fetch_step(1'b1, 1'b1)));
    @(posedge clk); #1;
    @(negedge clk);
    check("ill_hold2", 32'(act_a), 32'(q[4]));
    check("ill_b_decode", 32'(act_b), 32'(q[1] | step_t'({8'h01, 13'h0})));
    do_reset();

    // Reset while a store holds MemWrite
    opcode = 7'b0100011; func3 = 3'd2; func7 = '0;
    build(7'b0100011, 3'd2, 7'h00, 0, 0, 0, 0, 3);
    run("sw", 1'b0, 3);
    mem_ready = 1'b0;
    @(negedge clk);
    check("sw_memwrite", 32'(act_a), 32'(q[3]));
    #2 reset = 1'b0;
    #1 check("sw_rst_drop", 32'(act_a), 32'(fetch_step(1'b0, 1'b0)));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("sw_after_rst", 32'(act_a), 32'(fetch_step(1'b0, 1'b0)));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle RV32I control unit: a Moore FSM plus ALU/branch decode that drives the shared-memory multicycle datapath (PC, IR, OldPC, A/B, ALUOut, Data registers). Compared with the first-generation controller, it adds:
- full branch set, JALR, LUI/AUIPC;
- a wait-state memory handshake;
- a configurable ALU control width;
- illegal-instruction detection and a per-instruction retire pulse.

It sits between the instruction register and the datapath muxes and write enables.

## Interface
Parameters:
- ALU_CTRL_W, 4, width of ALUControl (≥4); encodings below are zero-extended.
- MEM_WAIT_EN, 1, 1: memory states wait for MemReady; 0: MemReady is ignored and treated as 1.
- HALT_ON_ILLEGAL, 1, 1: ILLEGAL state is terminal until reset; 0: ILLEGAL returns to FETCH.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low; low forces state FETCH and clears Illegal.
- opcode  input  7  IR[6:0].
- func3  input  3  IR[14:12].
- func7  input  7  IR[31:25].
- Zero  input  1  ALU result == 0.
- LessS  input  1  signed rs1 < rs2 (from SUB).
- LessU  input  1  unsigned rs1 < rs2 (from SUB).
- MemReady  input  1  memory completes the current access this cycle.
- MemReq  output  1  memory access request.
- IRWrite, MemWrite, AdrSrc, PCWrite, RegWrite  output  1 each  datapath enables/selects.
- ResultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  output  2  00 PC, 01 OldPC, 10 A(rs1), 11 zero.
- ALUSrcB  output  2  00 B(rs2), 01 ImmExt, 10 constant 4.
- ImmSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
- ALUControl  output  ALU_CTRL_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA.
- Retire  output  1  one-cycle pulse in the final cycle of each legal instruction.
- Illegal  output  1  sticky flag, set on entry to ILLEGAL.

## Operation
- All outputs are combinational functions of the state register, plus opcode/func/flags where noted.
- In any state, unlisted outputs are 0, ALUControl is ADD, and ImmSrc is 000.
- FETCH:
  - Drives MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite and PCWrite both equal MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01; ImmSrc=011 if opcode=1101111, else 010. ALUOut captures the branch/jump target.
  - Next state by opcode: 0000011/0100011 → MEMADR; 0110011 → EXECUTER; 0010011 → EXECUTEI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; 0110111/0010111 → UPPER; other → ILLEGAL.
  - EXECUTER with func7 ∉ {0000000, 0100000} → ILLEGAL.
  - BRANCH with func3 ∈ {010, 011} → ILLEGAL.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000 for load / 001 for store. Load → MEMREAD; store → MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Waits on MemReady, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1 → FETCH.
- MEMWRITE:
  - MemReq=1, MemWrite=1, AdrSrc=1. MemWrite is held until MemReady.
  - When MemReady=1: Retire=1 → FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00. ALUControl from func3, with func7[5] selecting SUB/SRA → ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000. func7[5] is honoured only for func3=101 (SRAI); 000 is always ADD → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1 → FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUControl=SUB, ResultSrc=00.
  - PCWrite=taken, by func3: 000 Zero, 001 !Zero, 100 LessS, 101 !LessS, 110 LessU, 111 !LessU.
  - Retire=1 → FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000 (target into ALUOut) → JAL. Clearing bit 0 of the target is done by the datapath.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 (PC ← ALUOut, ALUOut ← OldPC+4) → ALUWB.
- UPPER: ALUSrcB=01, ImmSrc=100. ALUSrcA=11 for LUI, 01 for AUIPC → ALUWB.
- ILLEGAL:
  - Illegal is set; all enables are 0.
  - HALT_ON_ILLEGAL=1: stay in ILLEGAL. HALT_ON_ILLEGAL=0: → FETCH next cycle.
  - Illegal remains set until reset.

## Timing
- Reset:
  - State is FETCH; Illegal=0, Retire=0, RegWrite=0, MemWrite=0.
  - Because FETCH outputs are decoded from state, MemReq=1 and ALUSrcB=10 immediately.
  - Asserting reset mid-instruction drops MemWrite/RegWrite/PCWrite combinationally, in the same cycle.
- Cycles per instruction with zero wait states, counting from the FETCH entry cycle: lw 5, sw 4, R/I 4, branch 3, jal 4, jalr 5, lui/auipc 4.
- Each cycle with MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. During that time outputs stay stable and no write enable other than the held MemWrite is asserted.
- Retire pulses exactly once per legal instruction and never in ILLEGAL.
- With MEM_WAIT_EN=0, the latencies above hold regardless of MemReady.

## Test plan
- add x3,x1,x2 (0x002081B3), MemReady=1: states FETCH, DECODE, EXECUTER, ALUWB. ALUControl=0 in EXECUTER; RegWrite and Retire high only in cycle 4.
- lw (0x0000A183) with MemReady held low for 2 cycles in FETCH and 3 cycles in MEMREAD: total 10 cycles. IRWrite/PCWrite pulse only on the MemReady cycle; RegWrite asserted in MEMWB with ResultSrc=01.
- bne (func3=001) with Zero=0 → PCWrite=1 in BRANCH. Repeat with Zero=1 → PCWrite=0. bltu with LessU=1 → PCWrite=1. Each takes 3 cycles with one Retire.
- jalr (0x000080E7): states FETCH, DECODE, JALR, JAL, ALUWB. PCWrite=1 in JAL; RegWrite=1 in ALUWB.
- Opcode 0x7F with HALT_ON_ILLEGAL=1: Illegal=1 from the cycle after DECODE and the FSM holds. Reset low → FETCH, Illegal=0. Repeat with parameter 0 → back to FETCH after 1 cycle with Illegal still 1.
- sw with reset asserted while MemWrite=1 in MEMWRITE: MemWrite falls in the same cycle; after release, FETCH with MemReq=1 and no Retire.
